// File: rtl/mnoz_5b_ster.sv
// Shift-and-add unsigned multiplier controller that sequences one external
// combinational adder through SZER steps to produce a 2*SZER-bit product.
module mnoz_5b_ster #(
    parameter int SZER = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  przerwij,
    input  logic [SZER-1:0]       mnozna,
    input  logic [SZER-1:0]       mnoznik,
    output logic [SZER-1:0]       sum_a,
    output logic [SZER-1:0]       sum_b,
    output logic                  sum_cin,
    input  logic [SZER-1:0]       sum_s,
    input  logic                  sum_cout,
    output logic [2*SZER-1:0]     iloczyn,
    output logic                  zajety,
    output logic                  gotowe
);

    typedef enum logic [1:0] {
        BEZCZYN = 2'd0,
        OBLICZ  = 2'd1,
        KONIEC  = 2'd2
    } stan_t;

    localparam logic [2:0] LICZ_MAX = 3'(SZER - 1);

    stan_t               stan_r;
    logic [SZER-1:0]     akum_r;
    logic [SZER-1:0]     mq_r;
    logic [SZER-1:0]     m_r;
    logic [2:0]          licz_r;
    logic [2*SZER-1:0]   iloczyn_r;
    logic                gotowe_r;

    // Control FSM and datapath registers; abort wins over the step update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan_r    <= BEZCZYN;
            akum_r    <= {SZER{1'b0}};
            mq_r      <= {SZER{1'b0}};
            m_r       <= {SZER{1'b0}};
            licz_r    <= 3'd0;
            iloczyn_r <= {(2*SZER){1'b0}};
            gotowe_r  <= 1'b0;
        end else begin
            gotowe_r <= 1'b0;
            case (stan_r)
                BEZCZYN: begin
                    if (start) begin
                        m_r    <= mnozna;
                        mq_r   <= mnoznik;
                        akum_r <= {SZER{1'b0}};
                        licz_r <= 3'd0;
                        stan_r <= OBLICZ;
                    end else begin
                        stan_r <= BEZCZYN;
                    end
                end
                OBLICZ: begin
                    if (przerwij) begin
                        stan_r <= BEZCZYN;
                    end else begin
                        // Adder carry becomes the new top bit as the pair shifts right.
                        {akum_r, mq_r} <= {sum_cout, sum_s, mq_r[SZER-1:1]};
                        licz_r         <= licz_r + 3'd1;
                        if (licz_r == LICZ_MAX) begin
                            stan_r <= KONIEC;
                        end else begin
                            stan_r <= OBLICZ;
                        end
                    end
                end
                KONIEC: begin
                    iloczyn_r <= {akum_r, mq_r};
                    gotowe_r  <= 1'b1;
                    stan_r    <= BEZCZYN;
                end
                default: begin
                    stan_r <= BEZCZYN;
                end
            endcase
        end
    end

    // Adder operands come straight from registered state.
    always_comb begin
        sum_a   = akum_r;
        sum_cin = 1'b0;
        if (mq_r[0]) begin
            sum_b = m_r;
        end else begin
            sum_b = {SZER{1'b0}};
        end
    end

    assign zajety  = (stan_r != BEZCZYN);
    assign gotowe  = gotowe_r;
    assign iloczyn = iloczyn_r;

endmodule

// File: tb/tb_mnoz_5b_ster.sv
// Scoreboard bench for mnoz_5b_ster: a driver pushes expected products, a
// monitor pops them on each gotowe pulse and checks value and latency.
module tb_mnoz_5b_ster;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       przerwij;
    logic [4:0] mnozna;
    logic [4:0] mnoznik;
    logic [4:0] sum_a;
    logic [4:0] sum_b;
    logic       sum_cin;
    logic [4:0] sum_s;
    logic       sum_cout;
    logic [9:0] iloczyn;
    logic       zajety;
    logic       gotowe;

    typedef struct {
        int prod;
        int due;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   cyc;
    int   last_prod;

    mnoz_5b_ster #(.SZER(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .przerwij (przerwij),
        .mnozna   (mnozna),
        .mnoznik  (mnoznik),
        .sum_a    (sum_a),
        .sum_b    (sum_b),
        .sum_cin  (sum_cin),
        .sum_s    (sum_s),
        .sum_cout (sum_cout),
        .iloczyn  (iloczyn),
        .zajety   (zajety),
        .gotowe   (gotowe)
    );

    // Behavioural model of the external 5-bit adder.
    assign {sum_cout, sum_s} = {1'b0, sum_a} + {1'b0, sum_b} + {5'b00000, sum_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic flag(input string nm, input int act, input int exp_v);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Monitor: every gotowe pulse must match the oldest outstanding multiply.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gotowe) begin
                if (q.size() == 0) begin
                    flag("unexpected_gotowe", int'(gotowe), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("iloczyn", int'(iloczyn), e.prod);
                    chk("latency", cyc, e.due);
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                flag("gotowe_timeout", int'(gotowe), 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_iloczyn"}, int'(iloczyn), 0);
        chk({nm, "_zajety"},  int'(zajety),  0);
        chk({nm, "_gotowe"},  int'(gotowe),  0);
        chk({nm, "_sum_a"},   int'(sum_a),   0);
        chk({nm, "_sum_b"},   int'(sum_b),   0);
        chk({nm, "_sum_cin"}, int'(sum_cin), 0);
    endtask

    // Issue one multiply at a negedge in an idle cycle; returns in the first
    // cycle where a new start can be accepted. abort_at=k aborts in OBLICZ cycle k.
    task automatic run_mul(input int a, input int b, input int abort_at, input bit hold, input int gap);
        int busy;
        exp_t e;
        busy    = 0;
        start   = 1'b1;
        mnozna  = 5'(a);
        mnoznik = 5'(b);
        if (abort_at == 0) begin
            e.prod = a * b;
            e.due  = cyc + 7;
            q.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            if (zajety) busy++;
            if (k == abort_at) begin
                przerwij = 1'b1;
                @(negedge clk);
                przerwij = 1'b0;
                start    = 1'b0;
                chk("abort_idle", int'(zajety), 0);
                chk("abort_iloczyn_held", int'(iloczyn), last_prod);
                repeat (gap) @(negedge clk);
                return;
            end
            if (hold) begin
                start   = 1'b1;
                mnozna  = 5'd3;
                mnoznik = 5'd3;
            end else begin
                start   = 1'($urandom_range(0, 1));
                mnozna  = 5'($urandom);
                mnoznik = 5'($urandom);
            end
            przerwij = 1'($urandom_range(0, 1)) & 1'(abort_at == 0 && k == 6);
            @(negedge clk);
        end
        if (zajety) busy++;
        start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycles", busy, 6);
        chk("idle_after_done", int'(zajety), 0);
        last_prod = a * b;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_prod = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        przerwij  = 1'b0;
        mnozna    = 5'd0;
        mnoznik   = 5'd0;

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'(zajety), 0);

        run_mul(31, 31, 0, 1'b0, 0);
        chk("max_product", int'(iloczyn), 961);
        run_mul(5, 6, 0, 1'b0, 1);
        run_mul(0, 27, 0, 1'b0, 0);
        run_mul(19, 1, 0, 1'b0, 2);
        run_mul(7, 9, 0, 1'b1, 0);
        chk("restart_ignored", int'(iloczyn), 63);
        run_mul(12, 12, 3, 1'b0, 0);
        chk("abort_keeps_63", int'(iloczyn), 63);

        // Reset in the second OBLICZ cycle discards the operation.
        start   = 1'b1;
        mnozna  = 5'd4;
        mnoznik = 5'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        q.delete();
        last_prod = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_iloczyn", int'(iloczyn), 0);
        run_mul(2, 3, 0, 1'b0, 0);
        chk("post_reset_product", int'(iloczyn), 6);

        for (int i = 0; i < 1024; i++) begin
            run_mul(i / 32, i % 32, 0, 1'b0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_mul(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), ab,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
